// File: rtl/ads_emu_pkg.sv
// Shared command codes and FSM encodings for the ADS slave emulator.
package ads_emu_pkg;

  localparam logic [15:0] CMD_SRESET = 16'h1004;
  localparam logic [15:0] CMD_REFV1  = 16'h1002;
  localparam logic [15:0] CMD_REFV2  = 16'h1005;
  localparam logic [15:0] CMD_INIT   = 16'h1000;
  localparam logic [15:0] CMD_NORM   = 16'h0000;

  // First and last falling edge that carries a command bit.
  localparam logic [4:0] FE_FIRST = 5'd2;
  localparam logic [4:0] FE_LAST  = 5'd17;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FRAME  = 2'd1,
    DECODE = 2'd2
  } frame_state_e;

  typedef enum logic {
    CIDLE = 1'b0,
    CBUSY = 1'b1
  } conv_state_e;

endpackage

// File: rtl/ads_edge_sync.sv
// Two-flop synchronizer with single-cycle rise/fall pulses on the synchronized level.
module ads_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic s1_q, s2_q, prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= d;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign q    = s2_q;
  assign rise = s2_q & ~prev_q;
  assign fall = ~s2_q & prev_q;

endmodule

// File: rtl/ads_slave_emu.sv
// ADS serial slave emulator: command frame decode, conversion busy timing, SDO shift-out.
// Define ADS_EMU_RAMP_EN to generate samples from an internal ramp instead of EMU_*DATA.
module ads_slave_emu
  import ads_emu_pkg::*;
#(
  parameter int unsigned BUSY_CYC  = 300,
  parameter logic [15:0] RAMP_STEP = 16'h0001
) (
  input  logic        CLK_100M,
  input  logic        CLK_RST_N,
  input  logic        ADS_CLK,
  input  logic        ADS_CS_N,
  input  logic        ADS_SDI,
  input  logic        ADS_CONVST,
  input  logic        ADS_RD,
  output logic        ADS_BUSY,
  output logic        ADS_SDOA,
  output logic        ADS_SDOB,
  input  logic [15:0] EMU_ADATA,
  input  logic [15:0] EMU_BDATA,
  output logic [15:0] CMD_WORD,
  output logic        CMD_VALID,
  output logic        FRAME_ERR,
  output logic [9:0]  REFDAC1,
  output logic [9:0]  REFDAC2,
  output logic        INIT_OK
);

  localparam int unsigned CNT_W = (BUSY_CYC > 1) ? $clog2(BUSY_CYC) : 1;

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic sdi_lvl, sdi_rise, sdi_fall;
  logic convst_lvl, convst_rise, convst_fall;

  ads_edge_sync u_sync_sclk (
    .clk(CLK_100M), .rst_n(CLK_RST_N), .d(ADS_CLK),
    .q(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );
  ads_edge_sync u_sync_cs (
    .clk(CLK_100M), .rst_n(CLK_RST_N), .d(ADS_CS_N),
    .q(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );
  ads_edge_sync u_sync_sdi (
    .clk(CLK_100M), .rst_n(CLK_RST_N), .d(ADS_SDI),
    .q(sdi_lvl), .rise(sdi_rise), .fall(sdi_fall)
  );
  ads_edge_sync u_sync_convst (
    .clk(CLK_100M), .rst_n(CLK_RST_N), .d(ADS_CONVST),
    .q(convst_lvl), .rise(convst_rise), .fall(convst_fall)
  );

  frame_state_e frame_q, frame_d;
  conv_state_e  conv_q, conv_d;

  logic [4:0]       fe_cnt_q, fe_inc;
  logic [15:0]      cmd_sr_q;
  logic [17:0]      sdoa_sr_q, sdob_sr_q;
  logic [15:0]      sample_a_q, sample_b_q;
  logic [15:0]      cmd_word_q;
  logic             cmd_valid_q, frame_err_q;
  logic [9:0]       refdac1_q, refdac2_q;
  logic             init_ok_q, pending_q, pend_sel_q;
  logic [CNT_W-1:0] busy_cnt_q;
  logic             rd_s1_q, rd_s2_q, rd_prev_q;
  logic             frame_ok, do_sreset, conv_start, rd_err;

  assign fe_inc     = (fe_cnt_q == 5'd31) ? fe_cnt_q : fe_cnt_q + 5'd1;
  assign frame_ok   = (fe_cnt_q >= FE_LAST);
  assign do_sreset  = (frame_q == DECODE) && frame_ok && !pending_q && (cmd_sr_q == CMD_SRESET);
  assign conv_start = (conv_q == CIDLE) && convst_rise;
  // RD is only a protocol checker: a strobe inside an open frame is a master timing fault.
  assign rd_err     = rd_s2_q && !rd_prev_q && (frame_q == FRAME) && !cs_lvl;

  always_comb begin
    frame_d = frame_q;
    unique case (frame_q)
      IDLE:    if (cs_fall) frame_d = FRAME;
      FRAME:   if (cs_rise) frame_d = DECODE;
      DECODE:  frame_d = IDLE;
      default: frame_d = IDLE;
    endcase
  end

  always_comb begin
    conv_d = conv_q;
    unique case (conv_q)
      CIDLE:   if (convst_rise) conv_d = CBUSY;
      CBUSY:   if (busy_cnt_q == '0) conv_d = CIDLE;
      default: conv_d = CIDLE;
    endcase
  end

  always_ff @(posedge CLK_100M or negedge CLK_RST_N) begin
    if (!CLK_RST_N) begin
      frame_q   <= IDLE;
      conv_q    <= CIDLE;
      rd_s1_q   <= 1'b0;
      rd_s2_q   <= 1'b0;
      rd_prev_q <= 1'b0;
    end else begin
      frame_q   <= frame_d;
      conv_q    <= conv_d;
      rd_s1_q   <= ADS_RD;
      rd_s2_q   <= rd_s1_q;
      rd_prev_q <= rd_s2_q;
    end
  end

  always_ff @(posedge CLK_100M or negedge CLK_RST_N) begin
    if (!CLK_RST_N) begin
      fe_cnt_q    <= '0;
      cmd_sr_q    <= '0;
      sdoa_sr_q   <= '0;
      sdob_sr_q   <= '0;
      cmd_word_q  <= '0;
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      refdac1_q   <= '0;
      refdac2_q   <= '0;
      init_ok_q   <= 1'b0;
      pending_q   <= 1'b0;
      pend_sel_q  <= 1'b0;
    end else begin
      cmd_valid_q <= 1'b0;
      frame_err_q <= rd_err;
      case (frame_q)
        IDLE: begin
          if (cs_fall) begin
            fe_cnt_q  <= '0;
            // Old sample is loaded even if a new one latches this same cycle.
            sdoa_sr_q <= {2'b00, sample_a_q};
            sdob_sr_q <= {2'b00, sample_b_q};
          end
        end
        FRAME: begin
          if (sclk_fall) begin
            fe_cnt_q <= fe_inc;
            if (fe_inc >= FE_FIRST) begin
              sdoa_sr_q <= {sdoa_sr_q[16:0], 1'b0};
              sdob_sr_q <= {sdob_sr_q[16:0], 1'b0};
            end
            if (fe_inc >= FE_FIRST && fe_inc <= FE_LAST) begin
              cmd_sr_q <= {cmd_sr_q[14:0], sdi_lvl};
            end
          end
        end
        DECODE: begin
          if (frame_ok) begin
            cmd_valid_q <= 1'b1;
            cmd_word_q  <= cmd_sr_q;
            if (pending_q) begin
              if (pend_sel_q) refdac2_q <= cmd_sr_q[9:0];
              else            refdac1_q <= cmd_sr_q[9:0];
              pending_q <= 1'b0;
            end else begin
              case (cmd_sr_q)
                CMD_SRESET: begin
                  refdac1_q <= '0;
                  refdac2_q <= '0;
                  init_ok_q <= 1'b0;
                  pending_q <= 1'b0;
                end
                CMD_REFV1: begin
                  pending_q  <= 1'b1;
                  pend_sel_q <= 1'b0;
                end
                CMD_REFV2: begin
                  pending_q  <= 1'b1;
                  pend_sel_q <= 1'b1;
                end
                CMD_INIT: init_ok_q <= 1'b1;
                CMD_NORM: ;
                default:  ;
              endcase
            end
          end else begin
            frame_err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ADS_EMU_RAMP_EN
  logic [15:0] ramp_q, ramp_nxt;
  assign ramp_nxt = ramp_q + RAMP_STEP;
`endif

  always_ff @(posedge CLK_100M or negedge CLK_RST_N) begin
    if (!CLK_RST_N) begin
      busy_cnt_q <= '0;
      sample_a_q <= '0;
      sample_b_q <= '0;
`ifdef ADS_EMU_RAMP_EN
      ramp_q     <= '0;
`endif
    end else begin
      if (conv_start) begin
        busy_cnt_q <= CNT_W'(BUSY_CYC - 1);
      end else if (conv_q == CBUSY && busy_cnt_q != '0) begin
        busy_cnt_q <= busy_cnt_q - CNT_W'(1);
      end
`ifdef ADS_EMU_RAMP_EN
      if (do_sreset) begin
        ramp_q <= '0;
      end else if (conv_start) begin
        ramp_q     <= ramp_nxt;
        sample_a_q <= ramp_nxt;
        sample_b_q <= ~ramp_nxt;
      end
`else
      if (conv_start) begin
        sample_a_q <= EMU_ADATA;
        sample_b_q <= EMU_BDATA;
      end
`endif
    end
  end

  assign ADS_BUSY  = (conv_q == CBUSY);
  assign ADS_SDOA  = sdoa_sr_q[17];
  assign ADS_SDOB  = sdob_sr_q[17];
  assign CMD_WORD  = cmd_word_q;
  assign CMD_VALID = cmd_valid_q;
  assign FRAME_ERR = frame_err_q;
  assign REFDAC1   = refdac1_q;
  assign REFDAC2   = refdac2_q;
  assign INIT_OK   = init_ok_q;

  logic unused_sig;
`ifdef ADS_EMU_RAMP_EN
  assign unused_sig = ^{sclk_lvl, sclk_rise, sdi_rise, sdi_fall, convst_lvl, convst_fall,
                        EMU_ADATA, EMU_BDATA};
`else
  assign unused_sig = ^{sclk_lvl, sclk_rise, sdi_rise, sdi_fall, convst_lvl, convst_fall,
                        RAMP_STEP, do_sreset};
`endif

endmodule

// File: tb/tb_ads_slave_emu.sv
// Scoreboard bench for ads_slave_emu: decode pulses, SDO words and BUSY width checked by monitors.
module tb_ads_slave_emu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ads_clk = 1'b1;
  logic        cs_n = 1'b1;
  logic        sdi = 1'b0;
  logic        convst = 1'b0;
  logic        rd = 1'b0;
  logic [15:0] adata = '0;
  logic [15:0] bdata = '0;
  logic        busy, sdoa, sdob, cmd_valid, frame_err, init_ok;
  logic [15:0] cmd_word;
  logic [9:0]  r1, r2;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic        err;
    logic [15:0] word;
    logic [9:0]  r1;
    logic [9:0]  r2;
    logic        init;
  } ev_t;

  typedef struct packed {
    logic        chk;
    logic [17:0] a;
    logic [17:0] b;
  } sdo_t;

  ev_t  ev_q[$];
  sdo_t sdo_q[$];
  int   busy_q[$];
  logic [15:0] last_word = '0;

`ifdef ADS_EMU_RAMP_EN
  localparam logic [15:0] A1 = 16'h0001, B1 = 16'hFFFE;
  localparam logic [15:0] A2 = 16'h0002, B2 = 16'hFFFD;
  localparam logic [15:0] A3 = 16'h0003, B3 = 16'hFFFC;
`else
  localparam logic [15:0] A1 = 16'hA5A5, B1 = 16'h5A5A;
  localparam logic [15:0] A2 = 16'h1234, B2 = 16'hEDCB;
  localparam logic [15:0] A3 = 16'h0F0F, B3 = 16'hF0F0;
`endif

  always #5 clk = ~clk;

  ads_slave_emu dut (
    .CLK_100M(clk), .CLK_RST_N(rst_n), .ADS_CLK(ads_clk), .ADS_CS_N(cs_n),
    .ADS_SDI(sdi), .ADS_CONVST(convst), .ADS_RD(rd), .ADS_BUSY(busy),
    .ADS_SDOA(sdoa), .ADS_SDOB(sdob), .EMU_ADATA(adata), .EMU_BDATA(bdata),
    .CMD_WORD(cmd_word), .CMD_VALID(cmd_valid), .FRAME_ERR(frame_err),
    .REFDAC1(r1), .REFDAC2(r2), .INIT_OK(init_ok)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({busy, sdoa, sdob, cmd_word, cmd_valid, frame_err, r1, r2, init_ok});
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Decode-pulse monitor.
  initial forever begin
    ev_t e;
    @(negedge clk);
    if (cmd_valid === 1'b1 || frame_err === 1'b1) begin
      if (ev_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got valid=%b err=%b expected no pulse", cmd_valid,
                 frame_err);
      end else begin
        e = ev_q.pop_front();
        chk("pulse_kind", 64'({cmd_valid, frame_err}), 64'({~e.err, e.err}));
        chk("cmd_word", 64'(cmd_word), 64'(e.word));
        chk("refdac1", 64'(r1), 64'(e.r1));
        chk("refdac2", 64'(r2), 64'(e.r2));
        chk("init_ok", 64'(init_ok), 64'(e.init));
      end
    end
  end

  // SDO monitor: one bit captured a few cycles after every ADS_CLK fall inside a frame.
  initial forever begin
    logic [17:0] ca, cb;
    int n;
    sdo_t s;
    @(negedge cs_n);
    ca = '0;
    cb = '0;
    n = 0;
    while (cs_n === 1'b0) begin
      @(negedge ads_clk or posedge cs_n);
      if (cs_n === 1'b0) begin
        repeat (5) @(posedge clk);
        #1;
        ca = {ca[16:0], sdoa};
        cb = {cb[16:0], sdob};
        n++;
      end
    end
    if (sdo_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_frame: got frame with %0d edges expected none", n);
    end else begin
      s = sdo_q.pop_front();
      if (s.chk) begin
        chk("sdo_edges", 64'(n), 64'd18);
        chk("sdoa_word", 64'(ca), 64'(s.a));
        chk("sdob_word", 64'(cb), 64'(s.b));
      end
    end
  end

  // BUSY width monitor.
  initial forever begin
    int run;
    @(posedge busy);
    run = 0;
    do begin
      @(negedge clk);
      if (busy === 1'b1) run++;
    end while (busy === 1'b1 && run < 1000);
    if (busy_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_busy: got %0d cycles expected no busy", run);
    end else begin
      chk("busy_cycles", 64'(run), 64'(busy_q.pop_front()));
    end
  end

  task automatic frame(input logic [15:0] cmd, input int nedge, input int rd_edge,
                       input logic err, input logic [9:0] er1, input logic [9:0] er2,
                       input logic einit, input logic schk, input logic [15:0] ea,
                       input logic [15:0] eb);
    int idx;
    sdo_q.push_back('{schk, {2'b00, ea}, {2'b00, eb}});
    if (rd_edge > 0) ev_q.push_back('{1'b1, last_word, er1, er2, einit});
    if (!err) last_word = cmd;
    ev_q.push_back('{err, last_word, er1, er2, einit});
    cs_n = 1'b0;
    cyc(8);
    for (int k = 1; k <= nedge; k++) begin
      idx = 17 - k;
      if (k >= 2 && k <= 17) sdi = cmd[idx];
      else sdi = 1'b0;
      cyc(4);
      ads_clk = 1'b0;
      cyc(8);
      ads_clk = 1'b1;
      if (k == rd_edge) begin
        rd = 1'b1;
        cyc(4);
        rd = 1'b0;
      end else begin
        cyc(4);
      end
    end
    cs_n = 1'b1;
    cyc(16);
  endtask

  task automatic conv(input logic [15:0] a, input logic [15:0] b, input logic poke);
    adata = a;
    bdata = b;
    busy_q.push_back(300);
    convst = 1'b1;
    cyc(8);
    convst = 1'b0;
    adata = 16'hDEAD;
    bdata = 16'hBEEF;
    cyc(100);
    if (poke) begin
      convst = 1'b1;
      cyc(8);
      convst = 1'b0;
    end else begin
      cyc(8);
    end
    cyc(240);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    cyc(5);
    chk("reset_outputs", all_outs(), 64'd0);
    rst_n = 1'b1;
    cyc(5);
    chk("post_reset_outputs", all_outs(), 64'd0);

    frame(16'h1002, 18, 0, 1'b0, 10'h000, 10'h000, 1'b0, 1'b1, 16'h0000, 16'h0000);
    frame(16'h03FF, 18, 0, 1'b0, 10'h3FF, 10'h000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    frame(16'h1000, 18, 0, 1'b0, 10'h3FF, 10'h000, 1'b1, 1'b0, 16'h0000, 16'h0000);
    frame(16'h1005, 18, 0, 1'b0, 10'h3FF, 10'h000, 1'b1, 1'b0, 16'h0000, 16'h0000);
    frame(16'h0155, 18, 0, 1'b0, 10'h3FF, 10'h155, 1'b1, 1'b0, 16'h0000, 16'h0000);
    frame(16'h1234, 18, 0, 1'b0, 10'h3FF, 10'h155, 1'b1, 1'b0, 16'h0000, 16'h0000);
    frame(16'h1004, 10, 0, 1'b1, 10'h3FF, 10'h155, 1'b1, 1'b0, 16'h0000, 16'h0000);
    frame(16'h1004, 18, 0, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0, 16'h0000, 16'h0000);

    conv(16'hA5A5, 16'h5A5A, 1'b0);
    frame(16'h0000, 18, 0, 1'b0, 10'h000, 10'h000, 1'b0, 1'b1, A1, B1);
    conv(16'h1234, 16'hEDCB, 1'b1);
    frame(16'h0000, 18, 0, 1'b0, 10'h000, 10'h000, 1'b0, 1'b1, A2, B2);
    conv(16'h0F0F, 16'hF0F0, 1'b0);
    frame(16'h0000, 18, 0, 1'b0, 10'h000, 10'h000, 1'b0, 1'b1, A3, B3);
    frame(16'h2222, 18, 5, 1'b0, 10'h000, 10'h000, 1'b0, 1'b1, A3, B3);

    frame(16'h1000, 18, 0, 1'b0, 10'h000, 10'h000, 1'b1, 1'b0, 16'h0000, 16'h0000);
    frame(16'h1002, 18, 0, 1'b0, 10'h000, 10'h000, 1'b1, 1'b0, 16'h0000, 16'h0000);
    frame(16'h02AA, 18, 0, 1'b0, 10'h2AA, 10'h000, 1'b1, 1'b0, 16'h0000, 16'h0000);

    // Reset after the 8th falling edge with CS_N held low; that frame must be abandoned.
    sdo_q.push_back('{1'b0, 18'h0, 18'h0});
    cs_n = 1'b0;
    cyc(8);
    for (int k = 1; k <= 18; k++) begin
      sdi = k[0];
      cyc(4);
      ads_clk = 1'b0;
      cyc(8);
      ads_clk = 1'b1;
      cyc(4);
      if (k == 8) begin
        rst_n = 1'b0;
        cyc(3);
        chk("midframe_reset_outputs", all_outs(), 64'd0);
        rst_n = 1'b1;
        cyc(4);
      end
    end
    cs_n = 1'b1;
    cyc(16);
    last_word = 16'h0000;
    frame(16'h1000, 18, 0, 1'b0, 10'h000, 10'h000, 1'b1, 1'b1, 16'h0000, 16'h0000);

    cyc(50);
    chk("events_drained", 64'(ev_q.size()), 64'd0);
    chk("frames_drained", 64'(sdo_q.size()), 64'd0);
    chk("busy_drained", 64'(busy_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got no completion expected finish within 2ms");
    $fatal(1, "watchdog expired");
  end

endmodule
